dcache_port_merger: RTL and testbench

Parametrised merger between NPORT load/store lanes (post-translation physical addresses) and the multi-slot dcache request port. It groups same-line cached requests into one cache access and issues at most one access per cycle. It tracks up to DEPTH outstanding accesses in an in-order queue and routes each `cache_data_ok` back to the lanes that took part in that access. It also supports a `cancel` that discards the responses of accesses already in flight.

---
 rtl/dcache_port_merger_if.sv | 68 ++++++
 rtl/dcache_port_merger.sv | 144 ++++++++++++++
 tb/tb_dcache_port_merger.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_port_merger_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_port_merger_if
// Brief    : Lane-side and cache-side bus bundle for dcache_port_merger.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 4
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 8
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 20
`endif

interface dcache_port_merger_if #(
    parameter int NPORT    = 2,
    parameter int DEPTH    = 4,
    parameter int OFFSET_W = `OFFSET_WIDTH,
    parameter int INDEX_W  = `INDEX_WIDTH,
    parameter int TAG_W    = `TAG_WIDTH
);
    logic [NPORT-1:0]          lane_req;
    logic [32*NPORT-1:0]       lane_pa;
    logic [NPORT-1:0]          lane_uncached;
    logic [NPORT-1:0]          lane_we;
    logic [2*NPORT-1:0]        lane_size;
    logic [4*NPORT-1:0]        lane_wstrb;
    logic [32*NPORT-1:0]       lane_wdata;
    logic [NPORT-1:0]          lane_addr_ok;
    logic [NPORT-1:0]          lane_data_ok;
    logic [32*NPORT-1:0]       lane_rdata;
    logic                      cancel;
    logic [NPORT-1:0]          cache_valid;
    logic                      cache_op;
    logic [TAG_W-1:0]          cache_tag;
    logic [INDEX_W-1:0]        cache_index;
    logic [OFFSET_W*NPORT-1:0] cache_offset;
    logic [4*NPORT-1:0]        cache_wstrb;
    logic [32*NPORT-1:0]       cache_wdata;
    logic [2*NPORT-1:0]        cache_size;
    logic                      cache_uncached;
    logic                      cache_addr_ok;
    logic                      cache_data_ok;
    logic [32*NPORT-1:0]       cache_rdata;
    logic [$clog2(DEPTH+1)-1:0] outstanding;
    logic                      proto_err;

    // slave: the merger itself; master: the surrounding lanes and cache
    modport slave (
        input  lane_req, lane_pa, lane_uncached, lane_we, lane_size, lane_wstrb,
               lane_wdata, cancel, cache_addr_ok, cache_data_ok, cache_rdata,
        output lane_addr_ok, lane_data_ok, lane_rdata, cache_valid, cache_op,
               cache_tag, cache_index, cache_offset, cache_wstrb, cache_wdata,
               cache_size, cache_uncached, outstanding, proto_err
    );

    modport master (
        output lane_req, lane_pa, lane_uncached, lane_we, lane_size, lane_wstrb,
               lane_wdata, cancel, cache_addr_ok, cache_data_ok, cache_rdata,
        input  lane_addr_ok, lane_data_ok, lane_rdata, cache_valid, cache_op,
               cache_tag, cache_index, cache_offset, cache_wstrb, cache_wdata,
               cache_size, cache_uncached, outstanding, proto_err
    );
endinterface

`default_nettype wire

// File: rtl/dcache_port_merger.sv
`default_nettype none
// ============================================================================
// Module   : dcache_port_merger
// Brief    : Merges same-line lane requests into one dcache access and routes
//            in-order responses back to the participating lanes.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 4
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 8
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 20
`endif

module dcache_port_merger #(
    parameter int NPORT    = 2,
    parameter int DEPTH    = 4,
    parameter int OFFSET_W = `OFFSET_WIDTH,
    parameter int INDEX_W  = `INDEX_WIDTH,
    parameter int TAG_W    = `TAG_WIDTH
) (
    input  wire logic           clk,
    input  wire logic           reset,
    dcache_port_merger_if.slave bus
);
    localparam int c_line_w = 32 - OFFSET_W;
    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(DEPTH);

    logic [NPORT-1:0]    w_group;
    logic                w_found;
    logic                w_chain;
    logic [c_line_w-1:0] w_lead_line;
    logic                w_lead_unc;
    logic                w_lead_we;
    logic                w_full;
    logic                w_empty;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_fwd;
    logic [NPORT-1:0]    w_valid;

    logic [c_ptr_w-1:0]  r_head;
    logic [c_ptr_w-1:0]  r_tail;
    logic [c_cnt_w-1:0]  r_count;
    logic [DEPTH-1:0]    r_discard;
    logic [NPORT-1:0]    r_mask [DEPTH];
    logic                r_proto_err;

    // Leader is the first requester; followers join while the prefix stays unbroken.
    always_comb begin
        w_group     = '0;
        w_found     = 1'b0;
        w_chain     = 1'b0;
        w_lead_line = '0;
        w_lead_unc  = 1'b0;
        w_lead_we   = 1'b0;
        for (int j = 0; j < NPORT; j++) begin
            if (bus.lane_req[j]) begin
                if (!w_found) begin
                    w_found     = 1'b1;
                    w_chain     = 1'b1;
                    w_group[j]  = 1'b1;
                    w_lead_line = bus.lane_pa[32*j+OFFSET_W +: c_line_w];
                    w_lead_unc  = bus.lane_uncached[j];
                    w_lead_we   = bus.lane_we[j];
                end else if (w_chain && !w_lead_unc && !bus.lane_uncached[j] &&
                             (bus.lane_we[j] == w_lead_we) &&
                             (bus.lane_pa[32*j+OFFSET_W +: c_line_w] == w_lead_line)) begin
                    w_group[j] = 1'b1;
                end else begin
                    w_chain = 1'b0;
                end
            end
        end
    end

    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);
    assign w_issue = w_found && !w_full && !bus.cancel;
    assign w_valid = w_issue ? w_group : '0;
    assign w_push  = w_issue && bus.cache_addr_ok;
    assign w_pop   = bus.cache_data_ok && !w_empty;
    assign w_fwd   = w_pop && !r_discard[r_head] && !bus.cancel;

    assign bus.cache_valid    = w_valid;
    assign bus.lane_addr_ok   = w_valid & {NPORT{bus.cache_addr_ok}};
    assign bus.cache_op       = w_lead_we;
    assign bus.cache_uncached = w_lead_unc;
    assign bus.cache_tag      = w_lead_line[c_line_w-1 -: TAG_W];
    assign bus.cache_index    = w_lead_line[INDEX_W-1:0];
    assign bus.outstanding    = r_count;
    assign bus.proto_err      = r_proto_err;

    for (genvar i = 0; i < NPORT; i++) begin : g_slot
        assign bus.cache_offset[i*OFFSET_W +: OFFSET_W] = bus.lane_pa[32*i +: OFFSET_W];
        assign bus.cache_wstrb[4*i +: 4]   = bus.lane_wstrb[4*i +: 4];
        assign bus.cache_wdata[32*i +: 32] = bus.lane_wdata[32*i +: 32];
        assign bus.cache_size[2*i +: 2]    = bus.lane_size[2*i +: 2];
        assign bus.lane_rdata[32*i +: 32]  = bus.cache_rdata[32*i +: 32];
        assign bus.lane_data_ok[i]         = w_fwd && r_mask[r_head][i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_discard   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            // cancel blocks issue, so a cancel and a push never share an edge
            if (bus.cancel) begin
                r_discard <= '1;
            end else if (w_push) begin
                r_discard[r_tail] <= 1'b0;
            end
            if (bus.cache_data_ok && w_empty) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Masks are only read for live entries, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mask[r_tail] <= w_group;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_dcache_port_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_port_merger
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            a randomized run against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_port_merger;
    localparam int NPORT    = 2;
    localparam int DEPTH    = 4;
    localparam int OFFSET_W = 4;
    localparam int INDEX_W  = 8;
    localparam int TAG_W    = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dcache_port_merger_if #(.NPORT(NPORT), .DEPTH(DEPTH), .OFFSET_W(OFFSET_W),
                            .INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus ();

    dcache_port_merger #(.NPORT(NPORT), .DEPTH(DEPTH), .OFFSET_W(OFFSET_W),
                         .INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] pa0;
        logic [31:0] pa1;
        logic [1:0]  unc;
        logic [1:0]  we;
        logic [1:0]  exp_valid;
        logic        exp_op;
        logic [19:0] exp_tag;
        logic [7:0]  exp_index;
    } vec_t;
    vec_t vt [8];

    typedef struct {
        logic [1:0] mask;
        bit         disc;
    } ent_t;
    ent_t mq [$];
    bit   m_perr;

    logic [1:0]  expq [$];
    logic [1:0]  m;
    logic [31:0] pool [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic idle();
        bus.lane_req = '0; bus.lane_pa = '0; bus.lane_uncached = '0; bus.lane_we = '0;
        bus.lane_size = '0; bus.lane_wstrb = '0; bus.lane_wdata = '0; bus.cancel = 1'b0;
        bus.cache_addr_ok = 1'b0; bus.cache_data_ok = 1'b0; bus.cache_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic lanes(input logic [1:0] req, input logic [31:0] pa0, input logic [31:0] pa1,
                         input logic [1:0] unc, input logic [1:0] we);
        bus.lane_req = req; bus.lane_pa = {pa1, pa0}; bus.lane_uncached = unc; bus.lane_we = we;
        bus.lane_size = 4'b1010; bus.lane_wstrb = 8'hFF; bus.lane_wdata = {32'h1111_0001, 32'h0000_0000};
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] pa_of(input int i);
        return bus.lane_pa[32*i +: 32];
    endfunction

    function automatic int ref_leader();
        for (int i = 0; i < NPORT; i++) if (bus.lane_req[i]) return i;
        return -1;
    endfunction

    // Leader plus the unbroken run of compatible requesters after it.
    function automatic logic [NPORT-1:0] ref_group();
        logic [NPORT-1:0] g = '0;
        int ld = ref_leader();
        logic [31:0] lpa, jpa;
        if (ld < 0) return g;
        g[ld] = 1'b1;
        lpa = pa_of(ld);
        for (int j = ld + 1; j < NPORT; j++) begin
            if (!bus.lane_req[j]) continue;
            jpa = pa_of(j);
            if ((jpa >> OFFSET_W) == (lpa >> OFFSET_W) && !bus.lane_uncached[ld] &&
                !bus.lane_uncached[j] && bus.lane_we[j] == bus.lane_we[ld])
                g[j] = 1'b1;
            else
                break;
        end
        return g;
    endfunction

    initial begin
        vt[0] = '{2'b11, 32'h1000_0040, 32'h1000_0044, 2'b00, 2'b00, 2'b11, 1'b0, 20'h10000, 8'h04};
        vt[1] = '{2'b11, 32'h1000_0040, 32'h2000_0040, 2'b00, 2'b00, 2'b01, 1'b0, 20'h10000, 8'h04};
        vt[2] = '{2'b11, 32'h1000_0040, 32'h1000_0044, 2'b01, 2'b00, 2'b01, 1'b0, 20'h10000, 8'h04};
        vt[3] = '{2'b10, 32'h1000_0040, 32'h2000_0080, 2'b00, 2'b10, 2'b10, 1'b1, 20'h20000, 8'h08};
        vt[4] = '{2'b11, 32'h1000_0040, 32'h1000_0048, 2'b00, 2'b10, 2'b01, 1'b0, 20'h10000, 8'h04};
        vt[5] = '{2'b11, 32'h3000_0120, 32'h3000_012C, 2'b00, 2'b11, 2'b11, 1'b1, 20'h30000, 8'h12};
        vt[6] = '{2'b11, 32'h1000_0040, 32'h1000_0044, 2'b11, 2'b11, 2'b01, 1'b1, 20'h10000, 8'h04};
        vt[7] = '{2'b00, 32'h0000_0000, 32'h0000_0000, 2'b00, 2'b00, 2'b00, 1'b0, 20'h00000, 8'h00};
        pool[0] = 32'h1000_0040; pool[1] = 32'h1000_0044; pool[2] = 32'h1000_004C;
        pool[3] = 32'h2000_0040; pool[4] = 32'h1000_0080;

        // reset state
        idle();
        reset = 1'b1;
        #3;
        chk("rst_valid", bus.cache_valid, 0);
        chk("rst_dok", bus.lane_data_ok, 0);
        chk("rst_outstanding", bus.outstanding, 0);
        chk("rst_proto_err", bus.proto_err, 0);
        chk("rst_tag", bus.cache_tag, 0);
        tick();
        reset = 1'b0;
        tick();

        // combinational grouping table (cache never accepts, queue stays empty)
        foreach (vt[i]) begin
            lanes(vt[i].req, vt[i].pa0, vt[i].pa1, vt[i].unc, vt[i].we);
            settle();
            chk($sformatf("vec%0d_valid", i), bus.cache_valid, vt[i].exp_valid);
            chk($sformatf("vec%0d_op", i), bus.cache_op, vt[i].exp_op);
            chk($sformatf("vec%0d_tag", i), bus.cache_tag, vt[i].exp_tag);
            chk($sformatf("vec%0d_index", i), bus.cache_index, vt[i].exp_index);
            tick();
        end
        idle();
        chk("tbl_outstanding", bus.outstanding, 0);

        // merged load and response routing
        lanes(2'b11, 32'h1000_0040, 32'h1000_0044, 2'b00, 2'b00);
        bus.cache_addr_ok = 1'b1;
        settle();
        chk("merge_valid", bus.cache_valid, 2'b11);
        chk("merge_aok", bus.lane_addr_ok, 2'b11);
        chk("merge_offset", bus.cache_offset, 8'h40);
        tick();
        idle();
        chk("merge_outstanding", bus.outstanding, 1);
        bus.cache_data_ok = 1'b1;
        bus.cache_rdata = {32'hBBBB_0001, 32'hAAAA_0000};
        settle();
        chk("merge_dok", bus.lane_data_ok, 2'b11);
        chk("merge_rdata", bus.lane_rdata, {32'hBBBB_0001, 32'hAAAA_0000});
        tick();
        idle();
        chk("merge_drained", bus.outstanding, 0);

        // different lines: lane 1 stalls then issues alone
        lanes(2'b11, 32'h1000_0040, 32'h2000_0040, 2'b00, 2'b00);
        bus.cache_addr_ok = 1'b1;
        settle();
        chk("split_valid0", bus.cache_valid, 2'b01);
        chk("split_aok0", bus.lane_addr_ok, 2'b01);
        tick();
        lanes(2'b10, 32'h1000_0040, 32'h2000_0040, 2'b00, 2'b00);
        bus.cache_addr_ok = 1'b1;
        settle();
        chk("split_valid1", bus.cache_valid, 2'b10);
        chk("split_tag1", bus.cache_tag, 20'h20000);
        tick();
        idle();
        bus.cache_data_ok = 1'b1;
        settle();
        chk("split_dok0", bus.lane_data_ok, 2'b01);
        tick();
        settle();
        chk("split_dok1", bus.lane_data_ok, 2'b10);
        tick();
        idle();
        chk("split_drained", bus.outstanding, 0);

        // fill to DEPTH, blocked issue while popping, resume
        for (int k = 0; k < DEPTH; k++) begin
            lanes(2'b01, 32'h1000_0040, 32'h0, 2'b00, 2'b00);
            bus.cache_addr_ok = 1'b1;
            tick();
        end
        chk("full_outstanding", bus.outstanding, DEPTH);
        bus.cache_data_ok = 1'b1;
        settle();
        chk("full_valid", bus.cache_valid, 2'b00);
        chk("full_dok", bus.lane_data_ok, 2'b01);
        tick();
        bus.cache_data_ok = 1'b0;
        chk("full_pop_outstanding", bus.outstanding, DEPTH - 1);
        settle();
        chk("full_resume_valid", bus.cache_valid, 2'b01);
        tick();
        idle();
        for (int k = 0; k < DEPTH; k++) begin
            bus.cache_data_ok = 1'b1;
            tick();
        end
        idle();
        chk("full_drained", bus.outstanding, 0);

        // pointer wrap: keep three in flight across ten push+pop cycles
        expq.delete();
        for (int k = 0; k < 3; k++) begin
            lanes(2'b01, 32'h1000_0040, 32'h2000_0040, 2'b00, 2'b00);
            bus.cache_addr_ok = 1'b1;
            tick();
            expq.push_back(2'b01);
        end
        for (int k = 0; k < 10; k++) begin
            m = k[0] ? 2'b10 : 2'b01;
            lanes(m, 32'h1000_0040, 32'h2000_0040, 2'b00, 2'b00);
            bus.cache_addr_ok = 1'b1;
            bus.cache_data_ok = 1'b1;
            settle();
            chk($sformatf("wrap%0d_dok", k), bus.lane_data_ok, expq.pop_front());
            chk($sformatf("wrap%0d_valid", k), bus.cache_valid, m);
            expq.push_back(m);
            tick();
        end
        idle();
        chk("wrap_outstanding", bus.outstanding, 3);
        for (int k = 0; k < 3; k++) begin
            bus.cache_data_ok = 1'b1;
            settle();
            chk($sformatf("wrap_drain%0d", k), bus.lane_data_ok, expq.pop_front());
            tick();
        end
        idle();

        // cancel discards in-flight responses and blocks issue that cycle
        for (int k = 0; k < 2; k++) begin
            lanes(2'b01, 32'h1000_0040, 32'h0, 2'b00, 2'b00);
            bus.cache_addr_ok = 1'b1;
            tick();
        end
        bus.cancel = 1'b1;
        settle();
        chk("cancel_valid", bus.cache_valid, 2'b00);
        tick();
        idle();
        bus.cache_data_ok = 1'b1;
        settle();
        chk("cancel_dok0", bus.lane_data_ok, 2'b00);
        tick();
        chk("cancel_out1", bus.outstanding, 1);
        settle();
        chk("cancel_dok1", bus.lane_data_ok, 2'b00);
        tick();
        idle();
        chk("cancel_out0", bus.outstanding, 0);
        lanes(2'b01, 32'h1000_0040, 32'h0, 2'b00, 2'b00);
        bus.cache_addr_ok = 1'b1;
        tick();
        idle();
        bus.cache_data_ok = 1'b1;
        settle();
        chk("post_cancel_dok", bus.lane_data_ok, 2'b01);
        tick();
        idle();

        // randomized run against the reference model
        do_reset();
        mq.delete();
        m_perr = 1'b0;
        for (int c = 0; c < 500; c++) begin
            logic [NPORT-1:0] g, ev, ed;
            bit issue, pop;
            int ld;
            logic [31:0] lpa;
            bus.lane_req = 2'($urandom_range(0, 3));
            bus.lane_pa = {pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)]};
            bus.lane_uncached = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            bus.lane_we = 2'($urandom_range(0, 3));
            bus.lane_size = 4'($urandom);
            bus.lane_wstrb = 8'($urandom);
            bus.lane_wdata = {$urandom, $urandom};
            bus.cache_addr_ok = ($urandom_range(0, 3) != 0);
            bus.cache_data_ok = ($urandom_range(0, 1) == 0);
            bus.cancel = ($urandom_range(0, 19) == 0);
            bus.cache_rdata = {$urandom, $urandom};
            settle();
            g = ref_group();
            issue = (g != 0) && (mq.size() < DEPTH) && !bus.cancel;
            ev = issue ? g : '0;
            pop = bus.cache_data_ok && (mq.size() > 0);
            ed = (pop && !mq[0].disc && !bus.cancel) ? mq[0].mask : '0;
            chk("rnd_valid", bus.cache_valid, ev);
            chk("rnd_aok", bus.lane_addr_ok, bus.cache_addr_ok ? ev : '0);
            chk("rnd_dok", bus.lane_data_ok, ed);
            chk("rnd_rdata", bus.lane_rdata, bus.cache_rdata);
            chk("rnd_outstanding", bus.outstanding, mq.size());
            chk("rnd_proto_err", bus.proto_err, m_perr);
            ld = ref_leader();
            if (ld >= 0) begin
                lpa = pa_of(ld);
                chk("rnd_op", bus.cache_op, bus.lane_we[ld]);
                chk("rnd_uncached", bus.cache_uncached, bus.lane_uncached[ld]);
                chk("rnd_tag", bus.cache_tag, lpa[31 -: TAG_W]);
                chk("rnd_index", bus.cache_index, lpa[OFFSET_W +: INDEX_W]);
            end
            if (bus.cancel) foreach (mq[i]) mq[i].disc = 1'b1;
            if (pop) void'(mq.pop_front());
            else if (bus.cache_data_ok) m_perr = 1'b1;
            if (issue && bus.cache_addr_ok) mq.push_back('{g, 1'b0});
            tick();
        end
        idle();

        // asynchronous reset drops in-flight entries; late response is an error
        do_reset();
        lanes(2'b01, 32'h1000_0040, 32'h0, 2'b00, 2'b00);
        bus.cache_addr_ok = 1'b1;
        tick();
        idle();
        chk("arst_pre_outstanding", bus.outstanding, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_outstanding", bus.outstanding, 0);
        tick();
        reset = 1'b0;
        bus.cache_data_ok = 1'b1;
        settle();
        chk("late_dok", bus.lane_data_ok, 2'b00);
        tick();
        idle();
        chk("perr_set", bus.proto_err, 1);
        tick();
        tick();
        chk("perr_sticky", bus.proto_err, 1);
        #2 reset = 1'b1;
        #1;
        chk("perr_async_clear", bus.proto_err, 0);
        tick();
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
